scan_sel_gen: RTL and testbench
===============================

SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 The block SHALL have one parameter: DIV, default 4, number of enabled clock cycles per select step (legal range 1..65535).
REQ-002 The port clk SHALL be an input, 1 bit wide, and serve as the single rising-edge clock.
REQ-003 The port rst SHALL be an input, 1 bit wide, and act as a synchronous, active-high reset.
REQ-004 The port en SHALL be an input, 1 bit wide; when high, the prescaler advances.
REQ-005 The port mode SHALL be an input, 2 bits wide, selecting 00 up, 01 down, 10 ping-pong or 11 hold.
REQ-006 The port load SHALL be an input, 1 bit wide, and request a synchronous preset of sel.
REQ-007 The port load_val SHALL be an input, 3 bits wide, and give the preset value for sel.
REQ-008 The port sel SHALL be an output, 3 bits wide and registered, and provide the index that drives the 3-to-8 one-hot decoder input directly.
REQ-009 The port tick SHALL be an output, 1 bit wide and registered, pulsing for one cycle in the same cycle that a newly stepped sel value first appears.
REQ-010 The port wrap SHALL be an output, 1 bit wide and registered, pulsing for one cycle in the same cycle as tick when the step was a wrap or a reversal.
REQ-011 The port dir SHALL be an output, 1 bit wide and registered, where 1 means counting up and 0 means counting down.

Function
REQ-012 Prescaler cnt SHALL be an internal counter of width ceil(log2(DIV)) (minimum 1 bit) that counts from 0 to DIV-1.
REQ-013 When en=1 and load=0, cnt SHALL increment by 1 each cycle, and when cnt==DIV-1 it SHALL return to 0 and generate a step.
REQ-014 When en=0 and load=0, cnt, sel and dir SHALL hold, and tick and wrap SHALL be 0.
REQ-015 When DIV=1, a step SHALL occur on every enabled cycle.
REQ-016 In up mode, a step SHALL set sel to sel+1 modulo 8 and force dir=1; the step 7->0 SHALL assert wrap.
REQ-017 In down mode, a step SHALL set sel to sel-1 modulo 8 and force dir=0; the step 0->7 SHALL assert wrap.
REQ-018 In ping-pong mode, a step with dir=1 and sel<7 SHALL increment sel, and a step with dir=0 and sel>0 SHALL decrement sel.
REQ-019 In ping-pong mode, a step at dir=1 and sel==7 SHALL set sel=6 and dir=0 and assert wrap; a step at dir=0 and sel==0 SHALL set sel=1 and dir=1 and assert wrap; no endpoint is emitted twice.
REQ-020 In hold mode, the prescaler SHALL still run, but a step SHALL leave sel and dir unchanged and keep tick and wrap at 0.
REQ-021 tick SHALL be 1 on every cycle following a non-hold step and 0 otherwise; wrap SHALL never be 1 while tick is 0.
REQ-022 When load=1, regardless of en and mode, the block SHALL set sel=load_val and cnt=0, leave dir unchanged, and drive tick and wrap to 0 on the next cycle.
REQ-023 A mode change SHALL take effect at the next step; the prescaler phase SHALL be unaffected by a mode change.
REQ-024 A step that coincides with load=1 SHALL be discarded.
REQ-025 All outputs SHALL be updated only on the rising edge of clk, with no combinational path from any input to any output.

Reset
REQ-026 When rst=1 at a clk edge, the block SHALL set sel=0, cnt=0, dir=1, tick=0 and wrap=0.
REQ-027 rst SHALL take priority over load and en, including when asserted mid-count or mid-reversal.
REQ-028 The first step after reset deassertion SHALL occur DIV enabled cycles later.

Verification
REQ-029 Up mode: with DIV=4, mode=00, en=1 held for 32 cycles after reset, sel SHALL follow 1,2,...,7,0 with each value appearing every 4 cycles, tick SHALL pulse 8 times, and wrap SHALL pulse once, on the cycle sel=0.
REQ-030 Ping-pong mode: with DIV=1, mode=10 for 16 cycles, sel SHALL follow 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2, with wrap pulsing on the cycles showing 6 (after 7) and 1 (after 0), and dir SHALL toggle at those cycles.
REQ-031 Load priority: with DIV=4, cnt=3, en=1 and load=1 with load_val=5, the next cycle SHALL show sel=5, tick=0 and cnt=0, and the next step SHALL occur 4 cycles later with sel=6 in up mode.
REQ-032 Gating: with DIV=4, en toggled high and low on alternate cycles, steps SHALL occur every 8 cycles, and sel SHALL remain stable while en=0.
REQ-033 Hold and down mode: with mode=11 for 12 cycles at DIV=2, sel SHALL be unchanged and tick=0; switching to mode=01 from sel=0 SHALL give sel=7 with wrap=1 and dir=0 at the first step.
REQ-034 Mid-run reset: rst=1 for one cycle while sel=4 in ping-pong mode with dir=0 SHALL give sel=0, dir=1, tick=0 and wrap=0 on the next cycle, and the next step SHALL then go to 1.

Source files
------------

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: prescaled 3-bit select index generator for a 3-to-8 one-hot
// decoder. A prescaler divides enabled cycles by DIV. Each prescaler step moves
// sel up, down, ping-pong between 0 and 7, or leaves it in place (hold).
// tick marks the first cycle a newly stepped sel is visible. wrap marks a
// 7->0 or 0->7 wrap, or a ping-pong reversal.
// All outputs come straight from flops, so there is no input-to-output
// combinational path.
module scan_sel_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] sel,
  output logic       tick,
  output logic       wrap,
  output logic       dir
);

  localparam int unsigned    CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          dir_q, dir_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          step;

  // A step fires on the enabled cycle where the prescaler sits at its
  // terminal count. With DIV=1 that is every enabled cycle.
  assign step = en && (cnt_q == CNT_MAX);

  // Next-state logic. load outranks any step, so a coincident step is
  // discarded. Hold mode keeps the prescaler running but suppresses the
  // sel/dir update and the tick/wrap pulses.
  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      sel_d = load_val;
      cnt_d = '0;
    end else if (en) begin
      cnt_d = step ? '0 : cnt_q + CW'(1);
      if (step) begin
        case (mode)
          MODE_UP: begin
            sel_d  = sel_q + 3'd1;
            dir_d  = 1'b1;
            tick_d = 1'b1;
            wrap_d = (sel_q == 3'd7);
          end
          MODE_DOWN: begin
            sel_d  = sel_q - 3'd1;
            dir_d  = 1'b0;
            tick_d = 1'b1;
            wrap_d = (sel_q == 3'd0);
          end
          MODE_PP: begin
            tick_d = 1'b1;
            if (dir_q) begin
              if (sel_q == 3'd7) begin
                // Reverse at the top without emitting 7 twice.
                sel_d  = 3'd6;
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end else begin
                sel_d = sel_q + 3'd1;
              end
            end else begin
              if (sel_q == 3'd0) begin
                // Reverse at the bottom without emitting 0 twice.
                sel_d  = 3'd1;
                dir_d  = 1'b1;
                wrap_d = 1'b1;
              end else begin
                sel_d = sel_q - 3'd1;
              end
            end
          end
          MODE_HOLD: begin
            sel_d = sel_q;
          end
          default: begin
            sel_d = sel_q;
          end
        endcase
      end
    end
  end

  // State register. rst overrides load and en.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= 3'd0;
      dir_q  <= 1'b1;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign sel  = sel_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen. Three instances run side by side from shared
// inputs, with DIV = 4, 1 and 2. A behavioral model predicts every cycle.
// Its predictions are queued as inputs are driven and are popped after the
// clock edge. Directed scenarios then check their headline results against
// constants.
module tb_scan_sel_gen;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load;
  logic [1:0] mode;
  logic [2:0] load_val;

  logic [2:0] sel_a, sel_b, sel_c;
  logic       tick_a, tick_b, tick_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       dir_a, dir_b, dir_c;

  scan_sel_gen #(.DIV(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .sel(sel_a), .tick(tick_a), .wrap(wrap_a), .dir(dir_a)
  );
  scan_sel_gen #(.DIV(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .sel(sel_b), .tick(tick_b), .wrap(wrap_b), .dir(dir_b)
  );
  scan_sel_gen #(.DIV(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .sel(sel_c), .tick(tick_c), .wrap(wrap_c), .dir(dir_c)
  );

  // ---------------- model state and scoreboard ----------------
  int  div_tab [3] = '{4, 1, 2};
  int  m_cnt   [3];
  int  m_sel   [3];
  bit  m_dir   [3];
  bit  m_tick  [3];
  bit  m_wrap  [3];

  logic [17:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  // Packed observed value {sel, dir, tick, wrap} of instance i.
  function automatic logic [5:0] obs(input int i);
    case (i)
      0:       return {sel_a, dir_a, tick_a, wrap_a};
      1:       return {sel_b, dir_b, tick_b, wrap_b};
      default: return {sel_c, dir_c, tick_c, wrap_c};
    endcase
  endfunction

  function automatic logic [5:0] pack_model(input int i);
    return {3'(m_sel[i]), m_dir[i], m_tick[i], m_wrap[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference behavior of one instance for one clock edge.
  task automatic model(input int i, input logic r, input logic e,
                       input logic [1:0] m, input logic l, input logic [2:0] lv);
    int nxt;
    m_tick[i] = 1'b0;
    m_wrap[i] = 1'b0;
    if (r) begin
      m_cnt[i] = 0;
      m_sel[i] = 0;
      m_dir[i] = 1'b1;
    end else if (l) begin
      m_sel[i] = int'(lv);
      m_cnt[i] = 0;
    end else if (e) begin
      m_cnt[i] = m_cnt[i] + 1;
      if (m_cnt[i] == div_tab[i]) begin
        m_cnt[i] = 0;
        if (m == 2'b00) begin
          m_tick[i] = 1'b1;
          m_wrap[i] = (m_sel[i] == 7);
          m_sel[i]  = (m_sel[i] + 1) % 8;
          m_dir[i]  = 1'b1;
        end else if (m == 2'b01) begin
          m_tick[i] = 1'b1;
          m_wrap[i] = (m_sel[i] == 0);
          m_sel[i]  = (m_sel[i] + 7) % 8;
          m_dir[i]  = 1'b0;
        end else if (m == 2'b10) begin
          m_tick[i] = 1'b1;
          nxt = m_dir[i] ? m_sel[i] + 1 : m_sel[i] - 1;
          if (nxt < 0 || nxt > 7) begin
            m_dir[i]  = !m_dir[i];
            nxt       = m_dir[i] ? m_sel[i] + 1 : m_sel[i] - 1;
            m_wrap[i] = 1'b1;
          end
          m_sel[i] = nxt;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                     input logic l, input logic [2:0] lv);
    logic [17:0] cur;
    rst = r; en = e; mode = m; load = l; load_val = lv;
    for (int i = 0; i < 3; i++) model(i, r, e, m, l, lv);
    exp_q.push_back({pack_model(2), pack_model(1), pack_model(0)});
    @(posedge clk);
    #1;
    cyc_n++;
    cur = exp_q.pop_front();
    for (int i = 0; i < 3; i++)
      check($sformatf("cyc%0d_u%0d", cyc_n, i), 32'(obs(i)), 32'(cur[i*6 +: 6]));
  endtask

  // ---------------- directed sequence ----------------
  int ticks, wraps;
  int pp_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int pp_wrap[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    // Reset state
    cyc(1, 0, 2'b00, 0, 3'd0);
    cyc(1, 1, 2'b00, 1, 3'd5);
    check("rst_state", 32'({sel_a, dir_a, tick_a, wrap_a}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));

    // Up mode, DIV=4, 32 enabled cycles
    ticks = 0; wraps = 0;
    for (int k = 0; k < 32; k++) begin
      cyc(0, 1, 2'b00, 0, 3'd0);
      if (tick_a) ticks++;
      if (wrap_a) begin
        wraps++;
        check("up_wrap_sel", 32'(sel_a), 32'd0);
      end
    end
    check("up_ticks", 32'(ticks), 32'd8);
    check("up_wraps", 32'(wraps), 32'd1);
    check("up_final_sel", 32'(sel_a), 32'd0);

    // Ping-pong, DIV=1, 16 cycles from reset
    cyc(1, 0, 2'b10, 0, 3'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 1, 2'b10, 0, 3'd0);
      check($sformatf("pp_sel%0d", k), 32'(sel_b), 32'(pp_exp[k]));
      check($sformatf("pp_wrap%0d", k), 32'(wrap_b), 32'(pp_wrap[k]));
    end
    check("pp_dir_end", 32'(dir_b), 32'd1);

    // Load priority, DIV=4: cnt reaches 3, then load coincides with the step
    cyc(1, 0, 2'b00, 0, 3'd0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 2'b00, 0, 3'd0);
    cyc(0, 1, 2'b00, 1, 3'd5);
    check("load_sel", 32'(sel_a), 32'd5);
    check("load_tick", 32'(tick_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 2'b00, 0, 3'd0);
      check("load_no_tick", 32'(tick_a), 32'd0);
    end
    cyc(0, 1, 2'b00, 0, 3'd0);
    check("load_next_sel", 32'(sel_a), 32'd6);
    check("load_next_tick", 32'(tick_a), 32'd1);

    // Gating, DIV=4: en alternates, so a step lands every 8 cycles
    cyc(1, 0, 2'b00, 0, 3'd0);
    ticks = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(0, (k % 2) == 0, 2'b00, 0, 3'd0);
      if (tick_a) ticks++;
    end
    check("gate_ticks", 32'(ticks), 32'd2);
    check("gate_sel", 32'(sel_a), 32'd2);

    // Hold then down, DIV=2
    cyc(1, 0, 2'b11, 0, 3'd0);
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 2'b11, 0, 3'd0);
      if (tick_c) ticks++;
    end
    check("hold_ticks", 32'(ticks), 32'd0);
    check("hold_sel", 32'(sel_c), 32'd0);
    cyc(0, 1, 2'b01, 0, 3'd0);
    cyc(0, 1, 2'b01, 0, 3'd0);
    check("down_first", 32'({sel_c, dir_c, tick_c, wrap_c}), 32'({3'd7, 1'b0, 1'b1, 1'b1}));

    // Mid-run reset during ping-pong descent, DIV=1
    cyc(1, 0, 2'b10, 0, 3'd0);
    for (int k = 0; k < 10; k++) cyc(0, 1, 2'b10, 0, 3'd0);
    check("mid_pre", 32'({sel_b, dir_b}), 32'({3'd4, 1'b0}));
    cyc(1, 1, 2'b10, 0, 3'd0);
    check("mid_rst", 32'({sel_b, dir_b, tick_b, wrap_b}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
    cyc(0, 1, 2'b10, 0, 3'd0);
    check("mid_next", 32'(sel_b), 32'd1);

    // Random traffic, checked cycle by cycle against the model
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0,
          3'($urandom_range(0, 7)));

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
